// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel divider, x/y raster counters, sync/blank decode,
// a pixel-clocked delay line for the DAC-side sync/blank, and frame/line event pulses.
module vga_timing_gen #(
  parameter int unsigned H_VA    = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VA    = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned HS_POL  = 0,
  parameter int unsigned VS_POL  = 0,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned PIPE    = 2,
  parameter int unsigned CW      = 10,
  parameter int unsigned FW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active,
  output logic          hs,
  output logic          vs,
  output logic          hs_d,
  output logic          vs_d,
  output logic          blank_n_d,
  output logic          sof,
  output logic          eol,
  output logic          eof,
  output logic [FW-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_VA + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VA + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SS    = H_VA + H_FP;
  localparam int unsigned H_SE    = H_VA + H_FP + H_SYNC;
  localparam int unsigned V_SS    = V_VA + V_FP;
  localparam int unsigned V_SE    = V_VA + V_FP + V_SYNC;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic          HS_ACT   = (HS_POL != 0);
  localparam logic          VS_ACT   = (VS_POL != 0);

  logic [DW-1:0] div_q;
  logic          line_end;
  logic          frame_end;
  logic [31:0]   xw;
  logic [31:0]   yw;

  // Reset is folded in so no pixel is ever signalled while the counters are being cleared.
  assign pix_en    = en && !rst && (div_q == DIV_LAST);
  assign line_end  = (x == H_LAST);
  assign frame_end = line_end && (y == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (en) begin
      div_q <= pix_en ? '0 : div_q + 1'b1;
      if (pix_en) begin
        x <= line_end ? '0 : x + 1'b1;
        if (line_end) begin
          y <= (y == V_LAST) ? '0 : y + 1'b1;
        end
        if (frame_end) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Widened copies keep the decode compares correct even when a total equals 2^CW.
  assign xw = 32'(x);
  assign yw = 32'(y);

  assign active = (xw < H_VA) && (yw < V_VA);
  assign hs     = ((xw >= H_SS) && (xw < H_SE)) ? HS_ACT : ~HS_ACT;
  assign vs     = ((yw >= V_SS) && (yw < V_SE)) ? VS_ACT : ~VS_ACT;

  assign sof = pix_en && (x == '0) && (y == '0);
  assign eol = pix_en && (xw == H_VA - 1) && (yw < V_VA);
  assign eof = pix_en && (xw == H_VA - 1) && (yw == V_VA - 1);

  generate
    if (PIPE == 0) begin : g_no_pipe
      assign hs_d      = hs;
      assign vs_d      = vs;
      assign blank_n_d = active;
    end else begin : g_pipe
      logic [2:0] stage_q [PIPE];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < int'(PIPE); i++) begin
            stage_q[i] <= {~HS_ACT, ~VS_ACT, 1'b0};
          end
        end else if (pix_en) begin
          stage_q[0] <= {hs, vs, active};
          for (int i = 1; i < int'(PIPE); i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign {hs_d, vs_d, blank_n_d} = stage_q[PIPE-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a small raster: outputs are predicted from a running
// pixel count and enabled-clock count, with positions and delayed sync derived arithmetically.
module tb_vga_timing_gen;

  localparam int unsigned H_VA = 12, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int unsigned V_VA = 6, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int unsigned HS_POL = 0, VS_POL = 1;
  localparam int unsigned CLK_DIV = 3, PIPE = 2, CW = 5, FW = 3;
  localparam int HT = int'(H_VA + H_FP + H_SYNC + H_BP);
  localparam int VT = int'(V_VA + V_FP + V_SYNC + V_BP);
  localparam int NCYC = 14000;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          pix_en;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          active, hs, vs, hs_d, vs_d, blank_n_d, sof, eol, eof;
  logic [FW-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VA(H_VA), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VA(V_VA), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CLK_DIV(CLK_DIV), .PIPE(PIPE),
    .CW(CW), .FW(FW)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pix_en   (pix_en),
    .x        (x),
    .y        (y),
    .active   (active),
    .hs       (hs),
    .vs       (vs),
    .hs_d     (hs_d),
    .vs_d     (vs_d),
    .blank_n_d(blank_n_d),
    .sof      (sof),
    .eol      (eol),
    .eof      (eof),
    .frame_cnt(frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {hs, vs, active} for the pixel with absolute index p since reset.
  function automatic logic [2:0] decode(input int p);
    int px = p % HT;
    int py = (p / HT) % VT;
    logic h_in = (px >= int'(H_VA + H_FP)) && (px < int'(H_VA + H_FP + H_SYNC));
    logic v_in = (py >= int'(V_VA + V_FP)) && (py < int'(V_VA + V_FP + V_SYNC));
    logic h = h_in ? (HS_POL != 0) : (HS_POL == 0);
    logic v = v_in ? (VS_POL != 0) : (VS_POL == 0);
    return {h, v, (px < int'(H_VA)) && (py < int'(V_VA))};
  endfunction

  int       pix_cnt;   // pixels consumed since last reset
  int       clk_cnt;   // enabled clocks since last reset
  int       mx, my, mframe;
  logic     mpe;
  logic [2:0] now_dec, del_dec;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    pix_cnt = 0;
    clk_cnt = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      // First cycle is a held-off reset-state check; random resets only early in the run.
      if (c == 0) begin
        rst = 1'b0;
        en  = 1'b0;
      end else begin
        rst = (c < NCYC / 2) && ($urandom_range(0, 999) == 0);
        en  = ($urandom_range(0, 99) < 85);
      end
      #1;
      mx      = pix_cnt % HT;
      my      = (pix_cnt / HT) % VT;
      mframe  = (pix_cnt / (HT * VT)) % (1 << FW);
      mpe     = en && !rst && ((clk_cnt % int'(CLK_DIV)) == int'(CLK_DIV) - 1);
      now_dec = decode(pix_cnt);
      del_dec = (pix_cnt >= int'(PIPE)) ? decode(pix_cnt - int'(PIPE))
                                        : {HS_POL == 0, VS_POL == 0, 1'b0};
      check("pix_en", 32'(pix_en), 32'(mpe));
      check("x", 32'(x), 32'(mx));
      check("y", 32'(y), 32'(my));
      check("frame_cnt", 32'(frame_cnt), 32'(mframe));
      check("hs_vs_active", {29'd0, hs, vs, active}, {29'd0, now_dec});
      check("hs_vs_blank_d", {29'd0, hs_d, vs_d, blank_n_d}, {29'd0, del_dec});
      check("sof", 32'(sof), 32'(mpe && mx == 0 && my == 0));
      check("eol", 32'(eol), 32'(mpe && mx == int'(H_VA) - 1 && my < int'(V_VA)));
      check("eof", 32'(eof), 32'(mpe && mx == int'(H_VA) - 1 && my == int'(V_VA) - 1));
      if (rst) begin
        pix_cnt = 0;
        clk_cnt = 0;
      end else if (en) begin
        clk_cnt++;
        if (mpe) pix_cnt++;
      end
    end
    // The run must have wrapped the frame counter at least once after the last reset.
    check("frames_covered", 32'(pix_cnt > (HT * VT * (1 << FW))), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator, the successor to the fixed 640x480 counter/compare timing front-end. It produces the pixel-enable strobe, pixel coordinates, sync and blank signals, and frame/line event pulses for the renderers. Video timing, sync polarity, pixel-clock divide and render-pipeline delay are all parameters. It sits between the board clock and the scene/renderer logic, and its delayed outputs drive the DAC pins.

Parameters:
H_VA, 640, horizontal visible pixels
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_VA, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, active level of hs (0 = active-low)
VS_POL, 0, active level of vs
CLK_DIV, 2, clk cycles per pixel (>=1)
PIPE, 2, pixel delay applied to hs_d/vs_d/blank_n_d (>=0)
CW, 10, coordinate counter width (H_TOTAL and V_TOTAL must be <= 2^CW)
FW, 8, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  run enable; low freezes all timing
pix_en  out  1  one-clk strobe per pixel
x  out  CW  current horizontal count, 0..H_TOTAL-1
y  out  CW  current vertical count, 0..V_TOTAL-1
active  out  1  x<H_VA && y<V_VA
hs  out  1  undelayed hsync at HS_POL level
vs  out  1  undelayed vsync at VS_POL level
hs_d  out  1  hs delayed PIPE pixels
vs_d  out  1  vs delayed PIPE pixels
blank_n_d  out  1  active delayed PIPE pixels
sof  out  1  start-of-frame pulse
eol  out  1  end of visible line pulse
eof  out  1  end of visible frame pulse
frame_cnt  out  FW  frames completed, modulo 2^FW

Behaviour:
- Totals: H_TOTAL = H_VA+H_FP+H_SYNC+H_BP; V_TOTAL = V_VA+V_FP+V_SYNC+V_BP.
- Divider counts 0..CLK_DIV-1 while en=1. pix_en=1 in the cycle where div==CLK_DIV-1. With CLK_DIV=1, pix_en equals en.
- On each clock with pix_en=1:
  - x increments. At x==H_TOTAL-1, x goes to 0 and y increments.
  - At x==H_TOTAL-1 and y==V_TOTAL-1, y goes to 0 and frame_cnt increments, wrapping modulo 2^FW.
  - Wrap is exactly at TOTAL-1; no count of TOTAL is ever visible.
- x and y are the counter registers themselves.
- Combinational decode of the counter registers:
  - active = x<H_VA && y<V_VA (strict less-than).
  - hs = HS_POL when H_VA+H_FP <= x < H_VA+H_FP+H_SYNC, else ~HS_POL.
  - vs is the same rule on y with the V parameters and VS_POL.
- Delay line: PIPE-stage shift register of {hs, vs, active}, advanced only on pix_en. PIPE=0 makes the _d outputs equal hs/vs/active.
- Event pulses, each high for exactly one clk and only when pix_en=1:
  - sof: x==0 && y==0.
  - eol: x==H_VA-1 && y<V_VA.
  - eof: x==H_VA-1 && y==V_VA-1. eol is also high in this cycle.
- en=0: divider, x, y, frame_cnt and delay line hold; pix_en, sof, eol and eof are 0; hs/vs/active keep decoding the held counts. On en=1 the divider resumes from its held value.
- Reset (rst=1 at a clk edge, wins over en):
  - div=0, x=0, y=0, frame_cnt=0, pix_en=0.
  - All delay stages load hs=~HS_POL, vs=~VS_POL, active=0.
  - After the edge: active=1 (pixel 0,0), hs=~HS_POL, vs=~VS_POL, hs_d=~HS_POL, vs_d=~VS_POL, blank_n_d=0 (if PIPE>0).
  - Reset mid-frame behaves identically; no partial-line state survives.
- First pixel after reset: the first pix_en occurs CLK_DIV clocks after rst is released (with en=1), at x=0,y=0 with sof=1.

Test Plan:
- Defaults, reset then en=1 -> pix_en every 2nd clk; first pix_en at x=0,y=0 with sof=1; hs=0 for x 656..751 only; x 799->0 with y+1; eol at x=639 for y<480.
- Defaults, run a full frame (420000 pix_en) -> y 524->0; frame_cnt 0->1; eof at (639,479); vs=0 for y 490..491; sof again at (0,0).
- PIPE=2 -> hs_d equals hs delayed by exactly 2 pix_en strobes; hs_d=1 and blank_n_d=0 for the first 2 pixels after reset.
- en=0 at x=100,y=5 for 37 clks -> x,y,frame_cnt constant; pix_en, sof, eol, eof all 0; after en=1 the next pix_en gives x=101.
- rst=1 with en=1 at x=400,y=300 -> next clk x=0, y=0, frame_cnt=0, pix_en=0, blank_n_d=0, hs_d=~HS_POL.
- HS_POL=1, H_VA=4, H_FP=1, H_SYNC=2, H_BP=1, CLK_DIV=1, PIPE=0 -> hs=1 at x=5,6 only; eol at x=3; x wraps 7->0; pix_en constantly high.
